// File: rtl/sl_pkg.sv
// Shared definitions for the SL-link transmitter and receiver: FSM states,
// config register layout, length limits and frame-building helpers.
package sl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_STOP_LOW,
        ST_STOP_HIGH
    } sl_state_e;

    // Config register field positions.
    localparam int CFG_LEN_LSB    = 0;
    localparam int CFG_LEN_W      = 6;
    localparam int CFG_PARITY_BIT = 6;
    localparam int CFG_RSVD_BIT   = 7;
    localparam int CFG_HP_LSB     = 8;
    localparam int CFG_HP_W       = 8;

    localparam int LEN_MIN   = 8;
    localparam int LEN_MAX   = 32;
    localparam int WORD_W    = 32;
    localparam int FRAME_W   = LEN_MAX + 1;   // data plus optional parity bit
    localparam int BIT_CNT_W = 6;

    localparam logic [15:0] DEFAULT_CONFIG = 16'h0420;

    // Packed view of the config register; field order matches the bit positions above.
    typedef struct packed {
        logic [CFG_HP_W-1:0]  half_period;
        logic                 reserved;
        logic                 parity_en;
        logic [CFG_LEN_W-1:0] len;
    } sl_config_t;

    // Clamp the programmed word length into LEN_MIN..LEN_MAX.
    function automatic logic [CFG_LEN_W-1:0] eff_len(input logic [CFG_LEN_W-1:0] len);
        if (len < CFG_LEN_W'(LEN_MIN))
            return CFG_LEN_W'(LEN_MIN);
        else if (len > CFG_LEN_W'(LEN_MAX))
            return CFG_LEN_W'(LEN_MAX);
        else
            return len;
    endfunction

    // A half period of zero would stall the line; treat it as one cycle.
    function automatic logic [CFG_HP_W-1:0] eff_half_period(input logic [CFG_HP_W-1:0] hp);
        return (hp == '0) ? CFG_HP_W'(1) : hp;
    endfunction

    // Number of bit slots (data plus parity) in one frame, stop marker excluded.
    function automatic logic [BIT_CNT_W-1:0] frame_bits(input sl_config_t cfg);
        return eff_len(cfg.len) + BIT_CNT_W'(cfg.parity_en);
    endfunction

    // Masked data bits with the odd-parity bit placed just above them when enabled.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [WORD_W-1:0] word,
                                                       input sl_config_t        cfg);
        logic [CFG_LEN_W-1:0] len;
        logic [FRAME_W-1:0]   mask;
        logic [FRAME_W-1:0]   data;
        logic                 par;
        len  = eff_len(cfg.len);
        mask = (FRAME_W'(1) << len) - FRAME_W'(1);
        data = {1'b0, word} & mask;
        par  = ~(^data);
        if (cfg.parity_en)
            data = data | (FRAME_W'(par) << len);
        return data;
    endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// Half-period down-counter: reloaded on every state entry, ticks in the last
// cycle of the state so each LOW/HIGH phase lasts exactly half_period cycles.
module sl_bit_timer
    import sl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [CFG_HP_W-1:0] half_period,
    output logic                tick
);

    logic [CFG_HP_W-1:0] cnt_q;

    // Reload on state entry, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= eff_half_period(half_period) - CFG_HP_W'(1);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - CFG_HP_W'(1);
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/sl_tx.sv
// SL-link serial transmitter: takes config and data write strobes from the
// bridge, serialises words LSB first onto sl0/sl1 with an optional odd parity
// bit and a both-lines-low stop marker, with a one-word holding register.
module sl_tx
    import sl_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CONFIG = sl_pkg::DEFAULT_CONFIG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_data_tx,
    input  logic        data_we_tx,
    input  logic [15:0] wr_config_tx,
    input  logic        config_we_tx,
    output logic [15:0] rd_config_tx,
    output logic        config_changed_tx,
    output logic        rd_status_tx,
    output logic        status_changed_tx,
    output logic        sl0,
    output logic        sl1
);

    sl_state_e              state_q, state_d;
    sl_config_t             cfg_q, cfg_use;
    logic                   cfg_accept;
    logic                   cfg_changed_q;
    logic [WORD_W-1:0]      hold_q;
    logic                   hold_valid_q;
    logic                   hold_store;
    logic [FRAME_W-1:0]     frame_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   busy_q;
    logic                   load_new;
    logic                   load_hold;
    logic                   shift_bit;
    logic                   timer_load;
    logic                   tick;

    sl_bit_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (timer_load),
        .half_period (cfg_use.half_period),
        .tick        (tick)
    );

    // Config is writable only when fully idle; a same-cycle write applies to the word being started.
    always_comb begin
        cfg_accept = config_we_tx && (state_q == ST_IDLE) && !hold_valid_q;
        cfg_use    = cfg_accept ? sl_config_t'(wr_config_tx) : cfg_q;
    end

    // Config register and its one-cycle change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q         <= sl_config_t'(DEFAULT_CONFIG);
            cfg_changed_q <= 1'b0;
        end else begin
            cfg_changed_q <= cfg_accept;
            if (cfg_accept)
                cfg_q <= sl_config_t'(wr_config_tx);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d    = state_q;
        load_new   = 1'b0;
        load_hold  = 1'b0;
        shift_bit  = 1'b0;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_we_tx) begin
                    state_d    = ST_BIT_LOW;
                    load_new   = 1'b1;
                    timer_load = 1'b1;
                end
            end
            ST_BIT_LOW: begin
                if (tick) begin
                    state_d    = ST_BIT_HIGH;
                    timer_load = 1'b1;
                end
            end
            ST_BIT_HIGH: begin
                if (tick) begin
                    timer_load = 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(1)) begin
                        state_d = ST_STOP_LOW;
                    end else begin
                        state_d   = ST_BIT_LOW;
                        shift_bit = 1'b1;
                    end
                end
            end
            ST_STOP_LOW: begin
                if (tick) begin
                    state_d    = ST_STOP_HIGH;
                    timer_load = 1'b1;
                end
            end
            ST_STOP_HIGH: begin
                if (tick) begin
                    if (hold_valid_q) begin
                        state_d    = ST_BIT_LOW;
                        load_hold  = 1'b1;
                        timer_load = 1'b1;
                    end else if (data_we_tx) begin
                        // A word arriving in the last stop cycle goes straight out, no idle gap.
                        state_d    = ST_BIT_LOW;
                        load_new   = 1'b1;
                        timer_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Busy writes park in the holding register if it is empty; otherwise they are dropped.
    assign hold_store = data_we_tx && !hold_valid_q && (state_q != ST_IDLE) && !load_new;

    // Holding register valid flag.
    always_ff @(posedge clk) begin
        if (rst)
            hold_valid_q <= 1'b0;
        else if (load_hold)
            hold_valid_q <= 1'b0;
        else if (hold_store)
            hold_valid_q <= 1'b1;
    end

    // Holding register data.
    always_ff @(posedge clk) begin
        // NOTE: the data word has no reset; it is only read while hold_valid_q is set.
        if (hold_store)
            hold_q <= wr_data_tx;
    end

    // Frame shift register and remaining-bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q   <= '0;
            bit_cnt_q <= '0;
        end else if (load_new) begin
            frame_q   <= build_frame(wr_data_tx, cfg_use);
            bit_cnt_q <= frame_bits(cfg_use);
        end else if (load_hold) begin
            frame_q   <= build_frame(hold_q, cfg_q);
            bit_cnt_q <= frame_bits(cfg_q);
        end else if (shift_bit) begin
            frame_q   <= frame_q >> 1;
            bit_cnt_q <= bit_cnt_q - BIT_CNT_W'(1);
        end
    end

    // Previous busy value, used to flag status edges.
    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= 1'b0;
        else
            busy_q <= rd_status_tx;
    end

    // Line drive: one line low for a data bit, both low only for the stop marker.
    always_comb begin
        sl0 = 1'b1;
        sl1 = 1'b1;
        case (state_q)
            ST_BIT_LOW: begin
                if (frame_q[0])
                    sl1 = 1'b0;
                else
                    sl0 = 1'b0;
            end
            ST_STOP_LOW: begin
                sl0 = 1'b0;
                sl1 = 1'b0;
            end
            default: begin
                sl0 = 1'b1;
                sl1 = 1'b1;
            end
        endcase
    end

    assign rd_config_tx      = cfg_q;
    assign config_changed_tx = cfg_changed_q;
    assign rd_status_tx      = (state_q != ST_IDLE) || hold_valid_q;
    assign status_changed_tx = rd_status_tx ^ busy_q;

endmodule

// File: tb/tb_sl_tx.sv
// Directed bench for sl_tx: a negedge monitor decodes line pulses into a
// nibble log (0 = sl0 pulse, 1 = sl1 pulse, F = stop) and counts busy cycles
// and change pulses; expectations are hand-computed constants.
module tb_sl_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wr_data_tx = '0;
    logic        data_we_tx = 1'b0;
    logic [15:0] wr_config_tx = '0;
    logic        config_we_tx = 1'b0;
    logic [15:0] rd_config_tx;
    logic        config_changed_tx;
    logic        rd_status_tx;
    logic        status_changed_tx;
    logic        sl0;
    logic        sl1;

    sl_tx dut (
        .clk               (clk),
        .rst               (rst),
        .wr_data_tx        (wr_data_tx),
        .data_we_tx        (data_we_tx),
        .wr_config_tx      (wr_config_tx),
        .config_we_tx      (config_we_tx),
        .rd_config_tx      (rd_config_tx),
        .config_changed_tx (config_changed_tx),
        .rd_status_tx      (rd_status_tx),
        .status_changed_tx (status_changed_tx),
        .sl0               (sl0),
        .sl1               (sl1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line monitor.
    int           busy_cycles = 0;
    int           sc_pulses   = 0;
    int           cc_pulses   = 0;
    int           sym_n       = 0;
    logic [127:0] sym_log     = '0;
    logic         prev_idle   = 1'b1;
    logic         mon_clr     = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            busy_cycles = 0;
            sc_pulses   = 0;
            cc_pulses   = 0;
            sym_n       = 0;
            sym_log     = '0;
        end else begin
            if (rd_status_tx)      busy_cycles++;
            if (status_changed_tx) sc_pulses++;
            if (config_changed_tx) cc_pulses++;
            if (prev_idle && !(sl0 && sl1)) begin
                sym_log = {sym_log[123:0], (!sl0 && !sl1) ? 4'hF : (!sl0 ? 4'h0 : 4'h1)};
                sym_n++;
            end
        end
        prev_idle = sl0 && sl1;
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic write_cfg(input logic [15:0] v);
        @(posedge clk);
        #1;
        wr_config_tx = v;
        config_we_tx = 1'b1;
        @(posedge clk);
        #1;
        config_we_tx = 1'b0;
    endtask

    task automatic poke_data(input logic [31:0] v);
        @(posedge clk);
        #1;
        wr_data_tx = v;
        data_we_tx = 1'b1;
        @(posedge clk);
        #1;
        data_we_tx = 1'b0;
    endtask

    // Idle write: busy and its change pulse must appear, and a line must be low, one cycle later.
    task automatic send_word(input string tag, input logic [31:0] v);
        poke_data(v);
        check({tag, "_busy_rise"}, rd_status_tx, 1'b1);
        check({tag, "_status_pulse"}, status_changed_tx, 1'b1);
        check({tag, "_first_low"}, sl0 & sl1, 1'b0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!rd_status_tx) done = 1'b1;
        end
        #1;
        check({tag, "_idle_timeout"}, done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state
        check("rst_config", rd_config_tx, 16'h0420);
        check("rst_status", rd_status_tx, 1'b0);
        check("rst_sl0", sl0, 1'b1);
        check("rst_sl1", sl1, 1'b1);
        check("rst_cc", config_changed_tx, 1'b0);
        check("rst_sc", status_changed_tx, 1'b0);

        // 2: len 8, hp 1, data 0xA5
        write_cfg(16'h0108);
        check("t2_cfg", rd_config_tx, 16'h0108);
        check("t2_cfg_pulse", config_changed_tx, 1'b1);
        clear_mon();
        send_word("t2", 32'h0000_00A5);
        wait_idle("t2", 100);
        check("t2_syms", sym_log, 36'h10100101F);
        check("t2_nsym", sym_n, 9);
        check("t2_busy", busy_cycles, 18);
        check("t2_sc", sc_pulses, 2);

        // 3: parity on, data 0x01 -> parity bit 0
        write_cfg(16'h0148);
        clear_mon();
        send_word("t3", 32'h0000_0001);
        wait_idle("t3", 100);
        check("t3_syms", sym_log, 40'h100000000F);
        check("t3_busy", busy_cycles, 20);
        check("t3_sc", sc_pulses, 2);

        // 4 + 5a: back-to-back via holding register, drop when full, config write while busy
        write_cfg(16'h0108);
        clear_mon();
        send_word("t4", 32'h0000_0011);
        poke_data(32'h0000_0022);
        poke_data(32'h0000_0033);
        write_cfg(16'h0210);
        check("t5_busy_cfg", rd_config_tx, 16'h0108);
        check("t5_busy_cc", config_changed_tx, 1'b0);
        wait_idle("t4", 200);
        check("t4_syms", sym_log, 72'h10001000F01000100F);
        check("t4_nsym", sym_n, 18);
        check("t4_busy", busy_cycles, 36);
        check("t4_sc", sc_pulses, 2);
        check("t5_busy_cc_cnt", cc_pulses, 0);

        // 5b: same config write while idle
        write_cfg(16'h0210);
        check("t5_idle_cfg", rd_config_tx, 16'h0210);
        check("t5_idle_cc", config_changed_tx, 1'b1);
        @(posedge clk);
        #1;
        check("t5_cc_one_cycle", config_changed_tx, 1'b0);

        // 6: reset in the 5th cycle of a frame (len 16, hp 2)
        clear_mon();
        send_word("t6", 32'h0000_ABCD);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_sl0", sl0, 1'b1);
        check("t6_sl1", sl1, 1'b1);
        check("t6_status", rd_status_tx, 1'b0);
        check("t6_sc", status_changed_tx, 1'b0);
        check("t6_cfg", rd_config_tx, 16'h0420);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_sc_cnt", sc_pulses, 1);
        check("t6_still_idle", rd_status_tx, 1'b0);
        write_cfg(16'h0108);
        clear_mon();
        send_word("t6b", 32'h0000_003C);
        wait_idle("t6b", 100);
        check("t6b_syms", sym_log, 36'h00111100F);
        check("t6b_busy", busy_cycles, 18);

        // Boundaries: len 0 -> 8 and half_period 0 -> 1; bit 8 of the word is ignored
        write_cfg(16'h0000);
        clear_mon();
        send_word("len0", 32'h0000_01FF);
        wait_idle("len0", 100);
        check("len0_syms", sym_log, 36'h11111111F);
        check("len0_busy", busy_cycles, 18);

        // Boundary: len 63 -> 32
        write_cfg(16'h013F);
        clear_mon();
        send_word("len63", 32'h8000_0001);
        wait_idle("len63", 200);
        check("len63_nsym", sym_n, 33);
        check("len63_tail", sym_log[11:0], 12'h01F);
        check("len63_busy", busy_cycles, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sl_tx.md
Name: sl_tx

Overview:
- SL-link serial transmitter, sitting directly downstream of the FIFO-to-transceiver bridge.
- Consumes the bridge's TX write strobes (config, data) and reports config and status back through the bridge's read/changed ports.
- Serialises 8..32-bit words onto the two-wire SL line. A '0' bit is a low pulse on sl0, a '1' bit is a low pulse on sl1, and the stop marker is a low pulse on both lines.
- A one-word holding register lets the bridge queue the next word while the current one is shifting.

Parameters:
DEFAULT_CONFIG, 16'h0420, config register value after reset (len=32, parity off, half_period=4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_data_tx  in  32  word to transmit, LSB first, bits [len-1:0] used
data_we_tx  in  1  one-cycle write strobe for wr_data_tx
wr_config_tx  in  16  new config value
config_we_tx  in  1  one-cycle write strobe for wr_config_tx
rd_config_tx  out  16  current config register
config_changed_tx  out  1  one-cycle pulse when rd_config_tx has just been updated
rd_status_tx  out  1  busy: shifting or holding register valid
status_changed_tx  out  1  one-cycle pulse in the cycle rd_status_tx changes value
sl0  out  1  SL zero line, idle high
sl1  out  1  SL one line, idle high

Behaviour:
- Reset: sl0=sl1=1, rd_config_tx=DEFAULT_CONFIG, rd_status_tx=0, both changed pulses 0, holding register empty, FSM=IDLE.
- Reset asserted mid-word: the lines return high at the next edge and the word is discarded. No status_changed pulse is generated.
- Config fields:
  - [5:0] len: values <8 are treated as 8, values >32 as 32.
  - [6] parity_en: when set, one odd-parity bit over the sent data bits is appended after the data.
  - [7] reserved: stored, ignored.
  - [15:8] half_period: length in clk cycles of each low pulse and of each following high gap. Value 0 is treated as 1.
- Config write:
  - Accepted only when the FSM is IDLE and the holding register is empty. rd_config_tx updates at the next edge and config_changed_tx pulses in that same cycle.
  - A write while busy is ignored: no register change, no pulse.
- Data write in idle (cycle N):
  - rd_status_tx=1 and status_changed_tx=1 at N+1.
  - The first bit's low pulse starts at N+1.
  - If config_we_tx is asserted in the same cycle, the new config applies to this word.
- Data write while busy:
  - Holding register empty: the word is stored.
  - Holding register full: the word is dropped silently.
- FSM states: IDLE -> BIT_LOW -> BIT_HIGH -> (next bit: BIT_LOW | all bits sent: STOP_LOW) -> STOP_HIGH -> (holding valid: BIT_LOW with the held word | else IDLE).
  - Each LOW/HIGH state lasts half_period cycles.
  - In BIT_LOW only the line selected by the current bit is low. In STOP_LOW both lines are low.
- Frame length = 2*half_period*(len+parity_en+1) cycles.
- Back-to-back words: there are no idle cycles between STOP_HIGH and the next BIT_LOW.
- rd_status_tx falls in the cycle after the final STOP_HIGH cycle when no held word is pending. status_changed_tx pulses in that cycle.
- Down-counters are sized for half_period (8 bits) and bit index (6 bits). They never wrap, because they are reloaded on every state entry.
- Invariant: sl0 and sl1 are never both low outside STOP_LOW.

Decomposition:
- Package sl_pkg holds:
  - the FSM state enum;
  - config field bit positions;
  - LEN_MIN=8 and LEN_MAX=32;
  - the DEFAULT_CONFIG constant.
- It is shared with the future sl_rx.
- One sub-module, sl_bit_timer, is natural: it loads half_period and issues a one-cycle expiry tick.

Test Plan:
1. Reset, then read config -> rd_config_tx=16'h0420, rd_status_tx=0, sl0=sl1=1.
2. Write config 16'h0108 (len=8, no parity, hp=1), then data 0xA5 -> pulse lines sl1,sl0,sl1,sl0,sl0,sl1,sl0,sl1, then both low. Busy for exactly 18 cycles. Exactly two status_changed pulses.
3. Config 16'h0148 (parity on), data 0x01 -> 8 data pulses then a parity pulse on sl0 (odd parity, already odd). Frame = 20 cycles.
4. With config 16'h0108, write 0x11 then 0x22 two cycles later, and 0x33 while the holding register is full -> 0x11 and 0x22 sent back-to-back with no gap. 0x33 is never sent. Busy stays 1 for 36 cycles.
5. config_we_tx=16'h0210 while busy -> rd_config_tx unchanged, no config_changed pulse. Same write when idle -> updated, one pulse.
6. Assert rst in the 5th cycle of a frame -> next edge gives sl0=sl1=1 and rd_status_tx=0. A new write afterwards transmits correctly.
